jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller with a 4-bit instruction register, instruction decode, bypass register, IDCODE register and TDO mux.
- Sits directly upstream of the boundary scan register chain. Drives its shift_dr, update_dr and mode controls, and consumes its serial output.
- The whole TAP runs on the single test clock.

---
 rtl/jtag_tap_ctrl.sv | 114 +++++++++++
 tb/tb_jtag_tap_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state TAP FSM, instruction register and decode,
// bypass and IDCODE data registers, and the TDO mux in front of the boundary scan chain.
module jtag_tap_ctrl #(
    parameter logic [31:0] IDCODE   = 32'h1000_0001,
    parameter int          IR_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic                bsr_tdo,
    output logic                bsr_shift_dr,
    output logic                bsr_update_dr,
    output logic                bsr_mode,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] instr
);

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = '0;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(2);
    // The two LSBs "01" are what a debugger checks to find IR boundaries.
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101);

    tap_state_e          state_q;
    logic [IR_WIDTH-1:0] instr_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic                bypass_q;
    logic [31:0]         id_shift_q;

    logic sel_bsr;
    logic sel_id;

    // Unlisted opcodes fall through to bypass because neither select is raised.
    assign sel_bsr = (instr_q == OP_EXTEST) || (instr_q == OP_SAMPLE);
    assign sel_id  = (instr_q == OP_IDCODE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TLR;
            instr_q    <= OP_IDCODE;
            ir_shift_q <= IR_CAPTURE;
            bypass_q   <= 1'b0;
            id_shift_q <= IDCODE;
        end else begin
            case (state_q)
                TLR:      state_q <= tms ? TLR      : RTI;
                RTI:      state_q <= tms ? SEL_DR   : RTI;
                SEL_DR:   state_q <= tms ? SEL_IR   : CAP_DR;
                CAP_DR:   state_q <= tms ? EX1_DR   : SH_DR;
                SH_DR:    state_q <= tms ? EX1_DR   : SH_DR;
                EX1_DR:   state_q <= tms ? UPD_DR   : PAUSE_DR;
                PAUSE_DR: state_q <= tms ? EX2_DR   : PAUSE_DR;
                EX2_DR:   state_q <= tms ? UPD_DR   : SH_DR;
                UPD_DR:   state_q <= tms ? SEL_DR   : RTI;
                SEL_IR:   state_q <= tms ? TLR      : CAP_IR;
                CAP_IR:   state_q <= tms ? EX1_IR   : SH_IR;
                SH_IR:    state_q <= tms ? EX1_IR   : SH_IR;
                EX1_IR:   state_q <= tms ? UPD_IR   : PAUSE_IR;
                PAUSE_IR: state_q <= tms ? EX2_IR   : PAUSE_IR;
                EX2_IR:   state_q <= tms ? UPD_IR   : SH_IR;
                UPD_IR:   state_q <= tms ? SEL_DR   : RTI;
                default:  state_q <= TLR;
            endcase

            case (state_q)
                TLR:    instr_q    <= OP_IDCODE;
                UPD_IR: instr_q    <= ir_shift_q;
                CAP_IR: ir_shift_q <= IR_CAPTURE;
                SH_IR:  ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
                CAP_DR: begin
                    if (sel_id) id_shift_q <= IDCODE;
                    else if (!sel_bsr) bypass_q <= 1'b0;
                end
                SH_DR: begin
                    if (sel_id) id_shift_q <= {tdi, id_shift_q[31:1]};
                    else if (!sel_bsr) bypass_q <= tdi;
                end
                default: ;
            endcase
        end
    end

    // NOTE: a default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        tdo = 1'b0;
        if (state_q == SH_IR) begin
            tdo = ir_shift_q[0];
        end else if (state_q == SH_DR) begin
            if (sel_id)       tdo = id_shift_q[0];
            else if (sel_bsr) tdo = bsr_tdo;
            else              tdo = bypass_q;
        end
    end

    assign tdo_en        = (state_q == SH_IR) || (state_q == SH_DR);
    assign bsr_shift_dr  = (state_q == SH_DR)  && sel_bsr;
    assign bsr_update_dr = (state_q == UPD_DR) && sel_bsr;
    assign bsr_mode      = (instr_q == OP_EXTEST);
    assign tap_state     = state_q;
    assign instr         = instr_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: walks the TAP through reset, IDCODE read,
// IR load, EXTEST and BYPASS passes, and reset recovery, against hand-computed values.
module tb_jtag_tap_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       bsr_tdo;
    logic       bsr_shift_dr;
    logic       bsr_update_dr;
    logic       bsr_mode;
    logic [3:0] tap_state;
    logic [3:0] instr;

    int checks   = 0;
    int failures = 0;

    jtag_tap_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .tdo_en        (tdo_en),
        .bsr_tdo       (bsr_tdo),
        .bsr_shift_dr  (bsr_shift_dr),
        .bsr_update_dr (bsr_update_dr),
        .bsr_mode      (bsr_mode),
        .tap_state     (tap_state),
        .instr         (instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled there too, mid-cycle.
    task automatic tick(input logic t_tms, input logic t_tdi);
        tms = t_tms;
        tdi = t_tdi;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] id_seen;
        logic [3:0]  ir_seen;
        logic [3:0]  byp_seen;
        logic [3:0]  byp_pat;
        logic [3:0]  bsr_pat;
        int          en_cnt;
        int          shift_cnt;
        int          upd_cnt;
        logic [7:0]  extest_tms;

        rst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;
        @(negedge clk);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("rst_state", tap_state, 32'hF);
        check("rst_instr", instr, 32'h1);
        check("rst_bsr", {bsr_shift_dr, bsr_update_dr, bsr_mode}, 32'h0);
        check("rst_tdo_en", tdo_en, 32'h0);

        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("tlr_state", tap_state, 32'hF);
        check("tlr_instr", instr, 32'h1);
        check("tlr_bsr", {bsr_shift_dr, bsr_update_dr, bsr_mode}, 32'h0);

        // IDCODE read: TLR -> RTI -> SelDR -> CapDR -> ShDR
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("id_shdr_state", tap_state, 32'h2);
        id_seen = '0;
        en_cnt  = 0;
        for (int i = 0; i < 32; i++) begin
            id_seen[i] = tdo;
            if (tdo_en) en_cnt++;
            tick(i == 31, 1'b0);
        end
        check("id_value", id_seen, 32'h1000_0001);
        check("id_tdo_en_cnt", en_cnt, 32'd32);
        check("id_ex1dr_state", tap_state, 32'h1);
        check("id_ex1dr_tdo_en", tdo_en, 32'h0);
        tick(1'b1, 1'b0);
        check("id_upddr_state", tap_state, 32'h5);
        check("id_upddr_no_bsr_upd", bsr_update_dr, 32'h0);

        // IR load of EXTEST: UpdDR -> SelDR -> SelIR -> CapIR -> ShIR
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("ir_shir_state", tap_state, 32'hA);
        ir_seen = '0;
        for (int i = 0; i < 4; i++) begin
            ir_seen[i] = tdo;
            tick(i == 3, 1'b0);
        end
        check("ir_capture_tdo", ir_seen, 32'h5);
        check("ir_ex1ir_instr", instr, 32'h1);
        tick(1'b1, 1'b0);
        check("ir_updir_state", tap_state, 32'hD);
        check("ir_updir_instr_unchanged", instr, 32'h1);
        tick(1'b1, 1'b0);
        check("extest_instr", instr, 32'h0);
        check("extest_mode", bsr_mode, 32'h1);

        // EXTEST DR pass from SelDR: CapDR, ShDR x4, Ex1DR, UpdDR, SelDR
        extest_tms = 8'b1110_0000;
        bsr_pat    = 4'b0110;
        shift_cnt  = 0;
        upd_cnt    = 0;
        for (int i = 0; i < 9; i++) begin
            if (tap_state == 4'h2) begin
                bsr_tdo = bsr_pat[shift_cnt % 4];
                #1;
                check("extest_tdo_follows", tdo, bsr_tdo);
            end
            if (bsr_shift_dr)  shift_cnt++;
            if (bsr_update_dr) upd_cnt++;
            if (i < 8) tick(extest_tms[i], 1'b0);
        end
        check("extest_shift_cnt", shift_cnt, 32'd4);
        check("extest_update_cnt", upd_cnt, 32'd1);
        check("extest_end_state", tap_state, 32'h7);

        // Load BYPASS: SelDR -> SelIR -> CapIR -> ShIR, shift 1111, Ex1IR -> UpdIR -> RTI
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(i == 3, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("byp_instr", instr, 32'hF);
        check("byp_mode", bsr_mode, 32'h0);

        // Bypass DR shift of 1,0,1,1 with bsr_tdo held high to expose a wrong select
        bsr_tdo = 1'b1;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("byp_shdr_state", tap_state, 32'h2);
        byp_pat  = 4'b1101;
        byp_seen = '0;
        shift_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            byp_seen[i] = tdo;
            if (bsr_shift_dr) shift_cnt++;
            tick(i == 3, byp_pat[i]);
        end
        check("byp_tdo_seq", byp_seen, 32'hA);
        check("byp_no_bsr_shift", shift_cnt, 32'd0);

        // Reset mid-shift: Ex1DR -> UpdDR -> SelDR -> SelIR -> CapIR -> ShIR, 2 bits, then rst
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        tick(1'b0, 1'b1); tick(1'b0, 1'b1);
        check("midrst_pre_state", tap_state, 32'hA);
        rst = 1'b1;
        tick(1'b0, 1'b1);
        rst = 1'b0;
        check("midrst_state", tap_state, 32'hF);
        check("midrst_instr", instr, 32'h1);
        check("midrst_ir_shift", dut.ir_shift_q, 32'h5);

        // TLR -> RTI -> SelDR -> CapDR -> Ex1DR -> PauseDR, then tms=1 x5
        tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
        check("pausedr_state", tap_state, 32'h3);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        check("pausedr_to_tlr", tap_state, 32'hF);
        check("pausedr_tlr_instr", instr, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
